// File: rtl/tribus_pkg.sv
// Shared types and helpers for the tri-state bus receive monitor.
package tribus_pkg;

    typedef enum logic [1:0] {ClsIdle, ClsSingle, ClsMulti} cls_e;

    // Helpers take a zero-extended enable vector; NDRV must not exceed this.
    localparam int unsigned MaxDrv = 32;

    function automatic int unsigned popcount(logic [MaxDrv-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MaxDrv; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Lowest set bit wins; only meaningful when exactly one bit is set.
    function automatic int unsigned onehot_to_idx(logic [MaxDrv-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = MaxDrv - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

    function automatic cls_e classify(int unsigned n);
        if (n == 0) return ClsIdle;
        if (n == 1) return ClsSingle;
        return ClsMulti;
    endfunction

    // Prev-source is kept SRCW+1 bits wide; a set MSB means "no current driver".
    localparam bit SrcNoneFlag = 1'b1;

endpackage

// File: rtl/tribus_rx_monitor_if.sv
// Bus-side and consumer-side signals of the tri-state bus receive monitor.
interface tribus_rx_monitor_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NDRV  = 4
);
    localparam int unsigned SRCW = $clog2(NDRV);

    logic [WIDTH-1:0] bus;
    logic [NDRV-1:0]  drv_en;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SRCW-1:0]  out_src;
    logic [WIDTH-1:0] keep;
    logic             contention;
    logic             bus_float;
    logic             overflow;

    modport master (
        output bus, drv_en, clr, out_ready,
        input  out_valid, out_data, out_src, keep, contention, bus_float, overflow
    );

    modport slave (
        input  bus, drv_en, clr, out_ready,
        output out_valid, out_data, out_src, keep, contention, bus_float, overflow
    );
endinterface

// File: rtl/tribus_rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flags pushes dropped while full.
module tribus_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot the push lands in, so full+pop still accepts.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && o_full && !w_do_pop;
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PtrOne;
            if (w_do_pop)  r_rptr <= r_rptr + PtrOne;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/tribus_rx_monitor.sv
// Tri-state bus receiver: sampler, driver classifier, bus keeper, float/contention
// detection and a source-tagged transfer FIFO.
module tribus_rx_monitor
    import tribus_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NDRV        = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FLOAT_LIMIT = 15
) (
    input logic                i_clk,
    input logic                i_rn,
    tribus_rx_monitor_if.slave io_mon
);
    localparam int unsigned SRCW = $clog2(NDRV);
    localparam int unsigned FCW  = $clog2(FLOAT_LIMIT + 1);
    localparam logic [SRCW:0]  SrcNone  = {SrcNoneFlag, {SRCW{1'b0}}};
    localparam logic [FCW-1:0] FloatMax = FCW'(FLOAT_LIMIT);
    localparam logic [FCW-1:0] FloatOne = FCW'(1);

    logic [WIDTH-1:0]      r_s_bus;
    logic [NDRV-1:0]       r_s_en;
    logic [WIDTH-1:0]      r_keep;
    logic [SRCW:0]         r_prev;
    logic [FCW-1:0]        r_float_cnt;
    logic                  r_contention;
    logic                  r_overflow;

    cls_e                  w_cls;
    logic [SRCW-1:0]       w_src;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_drop;
    logic [SRCW+WIDTH-1:0] w_head;

    always_comb begin
        w_cls  = classify(popcount(MaxDrv'(r_s_en)));
        w_src  = SRCW'(onehot_to_idx(MaxDrv'(r_s_en)));
        w_push = (w_cls == ClsSingle) && (r_prev != {1'b0, w_src});
    end

    always_ff @(posedge i_clk) begin
        if (!i_rn) begin
            r_s_bus      <= '0;
            r_s_en       <= '0;
            r_keep       <= '0;
            r_prev       <= SrcNone;
            r_float_cnt  <= '0;
            r_contention <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_s_bus <= io_mon.bus;
            r_s_en  <= io_mon.drv_en;

            case (w_cls)
                ClsSingle: begin
                    r_keep      <= r_s_bus;
                    r_float_cnt <= '0;
                    r_prev      <= {1'b0, w_src};
                end
                ClsMulti: begin
                    r_float_cnt <= '0;
                    r_prev      <= SrcNone;
                end
                default: begin
                    if (r_float_cnt != FloatMax) r_float_cnt <= r_float_cnt + FloatOne;
                    r_prev <= SrcNone;
                end
            endcase

            // A fresh event in the same cycle outranks CLR.
            if (w_cls == ClsMulti)  r_contention <= 1'b1;
            else if (io_mon.clr)    r_contention <= 1'b0;

            if (w_drop)             r_overflow <= 1'b1;
            else if (io_mon.clr)    r_overflow <= 1'b0;
        end
    end

    assign w_pop = !w_empty && io_mon.out_ready;

    tribus_rx_fifo #(
        .WIDTH (SRCW + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rn    (i_rn),
        .i_push  (w_push),
        .i_data  ({w_src, r_s_bus}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    assign io_mon.out_valid  = !w_empty;
    assign io_mon.out_data   = w_head[WIDTH-1:0];
    assign io_mon.out_src    = w_head[WIDTH +: SRCW];
    assign io_mon.keep       = r_keep;
    assign io_mon.contention = r_contention;
    assign io_mon.bus_float  = (r_float_cnt == FloatMax);
    assign io_mon.overflow   = r_overflow;

    logic w_unused;
    assign w_unused = w_full;
endmodule

// File: tb/tb_tribus_rx_monitor.sv
// Directed and randomized bench for tribus_rx_monitor with a transfer-level model.
module tb_tribus_rx_monitor;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned NDRV        = 4;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned FLOAT_LIMIT = 15;

    logic       clk = 1'b0;
    logic       tb_rn = 1'b0;
    logic [7:0] tb_bus = '0;
    logic [3:0] tb_en = '0;
    logic       tb_clr = 1'b0;
    logic       tb_rdy = 1'b0;

    always #5 clk = ~clk;

    tribus_rx_monitor_if #(.WIDTH(WIDTH), .NDRV(NDRV)) u_if ();

    assign u_if.bus       = tb_bus;
    assign u_if.drv_en    = tb_en;
    assign u_if.clr       = tb_clr;
    assign u_if.out_ready = tb_rdy;

    tribus_rx_monitor #(
        .WIDTH       (WIDTH),
        .NDRV        (NDRV),
        .DEPTH       (DEPTH),
        .FLOAT_LIMIT (FLOAT_LIMIT)
    ) u_dut (
        .i_clk  (clk),
        .i_rn   (tb_rn),
        .io_mon (u_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: every bus cycle's observable effect lands one edge after it is sampled.
    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } ent_t;

    ent_t       m_q[$];
    logic [7:0] m_keep = '0;
    int         m_idle = 0;
    int         m_last = -1;
    bit         m_cont = 1'b0;
    bit         m_ovf  = 1'b0;
    logic [3:0] m_pend_en = '0;
    logic [7:0] m_pend_bus = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        int   n;
        int   src;
        bit   popped;
        bit   push;
        bit   drop;
        ent_t e;
        if (!tb_rn) begin
            m_q.delete();
            m_keep = '0;
            m_idle = 0;
            m_last = -1;
            m_cont = 1'b0;
            m_ovf  = 1'b0;
            m_pend_en  = '0;
            m_pend_bus = '0;
            return;
        end
        popped = (m_q.size() > 0) && tb_rdy;
        n      = $countones(m_pend_en);
        push   = 1'b0;
        drop   = 1'b0;
        src    = 0;
        if (n == 1) begin
            for (int i = 0; i < NDRV; i++) if (m_pend_en[i]) src = i;
            m_keep = m_pend_bus;
            m_idle = 0;
            if (src != m_last) begin
                if (m_q.size() == DEPTH && !popped) drop = 1'b1;
                else push = 1'b1;
            end
            m_last = src;
        end else if (n == 0) begin
            m_idle++;
            m_last = -1;
        end else begin
            m_idle = 0;
            m_last = -1;
        end
        if (popped) void'(m_q.pop_front());
        if (push) begin
            e.src  = 2'(src);
            e.data = m_pend_bus;
            m_q.push_back(e);
        end
        if (n >= 2)      m_cont = 1'b1;
        else if (tb_clr) m_cont = 1'b0;
        if (drop)        m_ovf = 1'b1;
        else if (tb_clr) m_ovf = 1'b0;
        m_pend_en  = tb_en;
        m_pend_bus = tb_bus;
    endtask

    task automatic check_all();
        chk("valid", 32'(u_if.out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("data", 32'(u_if.out_data), 32'(m_q[0].data));
            chk("src", 32'(u_if.out_src), 32'(m_q[0].src));
        end
        chk("keep", 32'(u_if.keep), 32'(m_keep));
        chk("contention", 32'(u_if.contention), 32'(m_cont));
        chk("float", 32'(u_if.bus_float), 32'(m_idle >= FLOAT_LIMIT));
        chk("overflow", 32'(u_if.overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic [3:0] en, input logic [7:0] bus, input logic rdy,
                        input logic clr);
        tb_en  = en;
        tb_bus = bus;
        tb_rdy = rdy;
        tb_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int unsigned r;
        logic [3:0]  en;

        // Reset state
        tb_rn = 1'b0;
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("rst_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_keep", 32'(u_if.keep), 32'd0);
        tb_rn = 1'b1;

        // Single driver held three cycles -> one transfer
        step(4'b0010, 8'hA5, 1'b1, 1'b0);
        step(4'b0010, 8'hA5, 1'b1, 1'b0);
        chk("t1_keep", 32'(u_if.keep), 32'hA5);
        chk("t1_valid_hi", 32'(u_if.out_valid), 32'd1);
        chk("t1_src", 32'(u_if.out_src), 32'd1);
        step(4'b0010, 8'hA5, 1'b1, 1'b0);
        chk("t1_valid_lo", 32'(u_if.out_valid), 32'd0);

        // Three back-to-back sources queue in order
        step(4'b0001, 8'h11, 1'b0, 1'b0);
        step(4'b0100, 8'h22, 1'b0, 1'b0);
        step(4'b0001, 8'h33, 1'b0, 1'b0);
        step(4'b0000, 8'h00, 1'b0, 1'b0);
        chk("t2_head", 32'(u_if.out_data), 32'h11);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t2_second", 32'(u_if.out_data), 32'h22);
        chk("t2_second_src", 32'(u_if.out_src), 32'd2);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t2_third", 32'(u_if.out_data), 32'h33);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t2_cont", 32'(u_if.contention), 32'd0);

        // Contention between transfers, then CLR
        step(4'b0001, 8'h44, 1'b1, 1'b0);
        step(4'b0110, 8'h55, 1'b1, 1'b0);
        step(4'b0010, 8'h66, 1'b1, 1'b0);
        chk("t3_cont", 32'(u_if.contention), 32'd1);
        chk("t3_keep", 32'(u_if.keep), 32'h44);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t3_sticky", 32'(u_if.contention), 32'd1);
        step(4'b0000, 8'h00, 1'b1, 1'b1);
        chk("t3_clr", 32'(u_if.contention), 32'd0);

        // Prolonged float
        step(4'b0001, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t4_float_pre", 32'(u_if.bus_float), 32'd0);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t4_float", 32'(u_if.bus_float), 32'd1);
        chk("t4_keep", 32'(u_if.keep), 32'h3C);
        step(4'b1000, 8'h77, 1'b1, 1'b0);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t4_float_drop", 32'(u_if.bus_float), 32'd0);
        step(4'b0000, 8'h00, 1'b1, 1'b0);

        // Overflow, then push accepted alongside a pop while full
        step(4'b0001, 8'hF1, 1'b0, 1'b0);
        step(4'b0010, 8'hF2, 1'b0, 1'b0);
        step(4'b0001, 8'hF3, 1'b0, 1'b0);
        step(4'b0010, 8'hF4, 1'b0, 1'b0);
        step(4'b0001, 8'hF5, 1'b0, 1'b0);
        chk("t5_no_ovf", 32'(u_if.overflow), 32'd0);
        step(4'b0100, 8'hF6, 1'b0, 1'b0);
        chk("t5_ovf", 32'(u_if.overflow), 32'd1);
        chk("t5_head", 32'(u_if.out_data), 32'hF1);
        step(4'b0000, 8'h00, 1'b1, 1'b0);
        chk("t5_head2", 32'(u_if.out_data), 32'hF2);
        step(4'b0000, 8'h00, 1'b0, 1'b0);

        // Reset with entries queued
        tb_rn = 1'b0;
        step(4'b0000, 8'h00, 1'b0, 1'b0);
        chk("t6_valid", 32'(u_if.out_valid), 32'd0);
        chk("t6_ovf", 32'(u_if.overflow), 32'd0);
        tb_rn = 1'b1;
        step(4'b0100, 8'h99, 1'b0, 1'b0);
        step(4'b0000, 8'h00, 1'b0, 1'b0);
        chk("t6_new_src", 32'(u_if.out_src), 32'd2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      en = 4'(1 << (r % 4));
            else if (r < 8) en = 4'b0000;
            else            en = 4'($urandom_range(0, 15));
            tb_rn = ($urandom_range(0, 99) != 0);
            step(en, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end
        tb_rn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
